// File: rtl/hilo_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit_if
//  Brief    : Operation/result bundle between the execute stage and the
//             HI/LO multiply-divide unit.
//  Revision : 1.0  initial release
// ============================================================================
interface hilo_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            op_valid;
  logic [5:0]      AluControl;
  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic            flush;
  logic            busy;
  logic            done;
  logic            div_zero;
  logic [XLEN-1:0] mf_result;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  // Execute stage side: issues operations, observes status and results
  modport master (
    output op_valid, AluControl, rs_val, rt_val, flush,
    input  busy, done, div_zero, mf_result, hi, lo
  );

  // Unit side
  modport slave (
    input  op_valid, AluControl, rs_val, rt_val, flush,
    output busy, done, div_zero, mf_result, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_muldiv_unit
//  Brief    : HI/LO register owner with iterative mult/multu/div/divu
//             (XLEN calc cycles + 1 sign-fix cycle) and mfhi/mflo/mthi/mtlo.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  hilo_muldiv_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic              is_div_q,   is_div_d;
  logic              neg_res_q,  neg_res_d;
  logic              neg_rem_q,  neg_rem_d;
  logic              dz_q,       dz_d;
  logic [XLEN-1:0]   b_q,        b_d;
  logic [2*XLEN-1:0] acc_q,      acc_d;
  logic [XLEN-1:0]   hi_q,       hi_d;
  logic [XLEN-1:0]   lo_q,       lo_d;
  logic              done_q,     done_d;
  logic              div_zero_q, div_zero_d;

  logic busy;
  logic code_ok;
  logic accept;
  logic op_signed;
  logic op_is_div;
  logic sign_a;
  logic sign_b;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;

  assign busy    = (state_q != S_IDLE);
  assign code_ok = (bus.AluControl inside {OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO,
                                           OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
  assign accept  = bus.op_valid && !busy && !bus.flush && code_ok;

  // Even codes of the mult/div group are the signed variants; bit 1 selects divide
  assign op_signed = ~bus.AluControl[0];
  assign op_is_div = bus.AluControl[1];
  assign sign_a    = op_signed & bus.rs_val[XLEN-1];
  assign sign_b    = op_signed & bus.rt_val[XLEN-1];
  assign mag_a     = sign_a ? -bus.rs_val : bus.rs_val;
  assign mag_b     = sign_b ? -bus.rt_val : bus.rt_val;

  // Shift-add step: acc = {partial product, unconsumed multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide step: acc = {partial remainder, dividend/quotient bits}
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_sub;
  logic [XLEN-1:0]   rem_new;
  logic [2*XLEN-1:0] div_next;
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign rem_ge   = (rem_sh >= {1'b0, b_q});
  assign rem_sub  = rem_sh[XLEN-1:0] - b_q;
  assign rem_new  = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
  assign div_next = {rem_new, acc_q[XLEN-2:0], rem_ge};

  // Sign-corrected results presented during the FIX cycle
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = dz_q ? '1 : (neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0]);
  assign rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // Next-state logic: accept/issue, iterate, sign-fix and write back, flush override
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    b_d        = b_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.AluControl)
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              state_d   = S_CALC;
              cnt_d     = CNT_W'(XLEN);
              is_div_d  = op_is_div;
              neg_res_d = sign_a ^ sign_b;
              neg_rem_d = sign_a;
              dz_d      = op_is_div && (bus.rt_val == '0);
              if (op_is_div) begin
                acc_d = {{XLEN{1'b0}}, mag_a};
                b_d   = mag_b;
              end else begin
                acc_d = {{XLEN{1'b0}}, mag_b};
                b_d   = mag_a;
              end
            end
            default: ;
          endcase
        end
      end
      S_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          lo_d       = quo_fix;
          hi_d       = rem_fix;
          div_zero_d = dz_q;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush cancels everything in flight and suppresses any write-back
    if (bus.flush) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
    end
  end

  // State and architectural registers, asynchronously cleared
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      b_q        <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mf_result = (bus.op_valid && !busy && bus.AluControl == OP_MFHI) ? hi_q :
                         (bus.op_valid && !busy && bus.AluControl == OP_MFLO) ? lo_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_muldiv_unit
//  Brief    : Self-checking bench for hilo_muldiv_unit: directed vector table,
//             randomized ops against an arithmetic reference model, and
//             hand-written flush/reset corner sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;

  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MTHI  = 6'd17;
  localparam logic [5:0] OP_MFLO  = 6'd18;
  localparam logic [5:0] OP_MTLO  = 6'd19;
  localparam logic [5:0] OP_MULT  = 6'd24;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_DIV   = 6'd26;
  localparam logic [5:0] OP_DIVU  = 6'd27;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hilo_muldiv_unit_if #(.XLEN(32)) bus_if ();

  hilo_muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_dz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.op_valid   = 1'b0;
    bus_if.AluControl = 6'd0;
    bus_if.rs_val     = 32'd0;
    bus_if.rt_val     = 32'd0;
    bus_if.flush      = 1'b0;
  endtask

  // Architectural meaning of each HI/LO op, written with plain integer arithmetic
  task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output logic edz);
    longint          sa, sb, q, r, p;
    longint unsigned pu;
    edz = 1'b0;
    eh  = '0;
    el  = '0;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      OP_MULT:  begin p  = sa * sb;                  eh = p[63:32];  el = p[31:0];  end
      OP_MULTU: begin pu = {32'd0, a} * {32'd0, b};  eh = pu[63:32]; el = pu[31:0]; end
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) begin
          edz = 1'b1;
          el  = 32'hFFFF_FFFF;
          eh  = a;
        end else if (op == OP_DIV) begin
          q = sa / sb;  r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = a / b;   eh = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Issue one mult/div op and follow it to completion, checking timing and results
  task automatic run_muldiv(input string name, input logic [5:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                            input logic edz);
    int cyc;
    bus_if.op_valid   = 1'b1;
    bus_if.AluControl = op;
    bus_if.rs_val     = a;
    bus_if.rt_val     = b;
    step();
    bus_if.op_valid = 1'b0;
    cyc = 0;
    while (bus_if.busy && cyc < 100) begin
      cyc++;
      step();
    end
    check({name, " busy_cycles"}, 64'(cyc), 64'd33);
    check({name, " done"},        64'(bus_if.done), 64'd1);
    check({name, " div_zero"},    64'(bus_if.div_zero), 64'(edz));
    check({name, " hi"},          64'(bus_if.hi), 64'(eh));
    check({name, " lo"},          64'(bus_if.lo), 64'(el));
    step();
    check({name, " done_pulse_end"}, 64'({bus_if.done, bus_if.div_zero}), 64'd0);
  endtask

  task automatic write_hilo(input logic [5:0] op, input logic [31:0] v);
    bus_if.op_valid   = 1'b1;
    bus_if.AluControl = op;
    bus_if.rs_val     = v;
    step();
    bus_if.op_valid = 1'b0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [31:0] eh, el, ra, rb, hi_save;
    logic        edz;
    logic [5:0]  rop;
    int          seen_done;

    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst_n = 1'b0;

    vecs[0] = '{"multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{"mult_m3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{"mult_minsq", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[3] = '{"div_m7d2",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4] = '{"divu_100d7", OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5] = '{"div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[6] = '{"divu_5d0",   OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};

    #22 rst_n = 1'b1;
    step();

    // Reset state
    check("reset hi",   64'(bus_if.hi), 64'd0);
    check("reset lo",   64'(bus_if.lo), 64'd0);
    check("reset busy", 64'({bus_if.busy, bus_if.done, bus_if.div_zero}), 64'd0);

    // mthi / mtlo then read back through mfhi / mflo
    write_hilo(OP_MTHI, 32'h1234_5678);
    bus_if.op_valid = 1'b1; bus_if.AluControl = OP_MFHI; #1;
    check("mfhi after mthi", 64'(bus_if.mf_result), 64'h1234_5678);
    bus_if.AluControl = OP_MTLO; bus_if.rs_val = 32'h9ABC_DEF0;
    step();
    bus_if.AluControl = OP_MFLO; #1;
    check("mflo after mtlo", 64'(bus_if.mf_result), 64'h9ABC_DEF0);
    check("mt no done", 64'(bus_if.done), 64'd0);
    bus_if.op_valid = 1'b0; #1;
    check("mf idle zero", 64'(bus_if.mf_result), 64'd0);
    step();

    // Directed vector table
    for (int i = 0; i < 7; i++)
      run_muldiv(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_dz);

    // mfhi while busy returns zero
    bus_if.op_valid = 1'b1; bus_if.AluControl = OP_MULT;
    bus_if.rs_val = 32'd3; bus_if.rt_val = 32'd4;
    step();
    bus_if.AluControl = OP_MFHI;
    repeat (3) step();
    check("mfhi while busy", 64'({bus_if.busy, bus_if.mf_result}), {31'd0, 1'b1, 32'd0});
    bus_if.op_valid = 1'b0;
    repeat (40) step();
    check("mult 3x4 lo", 64'(bus_if.lo), 64'd12);

    // Unrecognised code: no state change
    hi_save = bus_if.hi;
    bus_if.op_valid = 1'b1; bus_if.AluControl = 6'd20; bus_if.rs_val = 32'hDEAD_BEEF;
    step();
    bus_if.op_valid = 1'b0;
    check("bad code ignored", 64'({bus_if.busy, bus_if.hi}), {31'd0, 1'b0, hi_save});

    // Randomized ops against the reference model
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: rop = OP_MULT;
        1: rop = OP_MULTU;
        2: rop = OP_DIV;
        default: rop = OP_DIVU;
      endcase
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
           ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : 32'($urandom);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      model(rop, ra, rb, eh, el, edz);
      run_muldiv($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, eh, el, edz);
      if ($urandom_range(0, 2) == 0) begin
        ra = $urandom;
        write_hilo(OP_MTLO, ra);
        bus_if.op_valid = 1'b1; bus_if.AluControl = OP_MFLO; #1;
        check($sformatf("rand%0d mflo", i), 64'(bus_if.mf_result), 64'(ra));
        bus_if.op_valid = 1'b0;
        step();
      end
    end

    // Flush during CALC
    write_hilo(OP_MTHI, 32'hAAAA_0000);
    bus_if.op_valid = 1'b1; bus_if.AluControl = OP_DIV;
    bus_if.rs_val = 32'd1000; bus_if.rt_val = 32'd3;
    step();
    bus_if.op_valid = 1'b0;
    repeat (9) step();
    bus_if.flush = 1'b1;
    step();
    bus_if.flush = 1'b0;
    check("flush calc busy", 64'(bus_if.busy), 64'd0);
    seen_done = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus_if.done || bus_if.div_zero) seen_done++;
      step();
    end
    check("flush calc no done", 64'(seen_done), 64'd0);
    check("flush calc hi", 64'(bus_if.hi), 64'hAAAA_0000);

    // Flush coinciding with the FIX edge
    bus_if.op_valid = 1'b1; bus_if.AluControl = OP_DIV;
    bus_if.rs_val = 32'd1000; bus_if.rt_val = 32'd0;
    step();
    bus_if.op_valid = 1'b0;
    repeat (32) step();
    check("fix cycle busy", 64'(bus_if.busy), 64'd1);
    bus_if.flush = 1'b1;
    step();
    bus_if.flush = 1'b0;
    check("flush fix done", 64'({bus_if.busy, bus_if.done, bus_if.div_zero}), 64'd0);
    check("flush fix hi", 64'(bus_if.hi), 64'hAAAA_0000);
    step();
    check("flush fix later", 64'({bus_if.done, bus_if.div_zero}), 64'd0);

    // Flushed mthi does not write
    bus_if.flush = 1'b1;
    write_hilo(OP_MTHI, 32'h5555_5555);
    bus_if.flush = 1'b0;
    check("flushed mthi", 64'(bus_if.hi), 64'hAAAA_0000);

    // Asynchronous reset mid-CALC
    bus_if.op_valid = 1'b1; bus_if.AluControl = OP_MULTU;
    bus_if.rs_val = 32'd9; bus_if.rt_val = 32'd9;
    step();
    bus_if.op_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("async rst hilo", {bus_if.hi, bus_if.lo}, 64'd0);
    check("async rst busy", 64'({bus_if.busy, bus_if.done}), 64'd0);
    #2 rst_n = 1'b1;
    repeat (40) step();
    check("post rst idle", 64'({bus_if.busy, bus_if.done, bus_if.lo}), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
